// File: rtl/onehot_codec.sv
// Registered binary/one-hot converter with a 2-entry output buffer, illegal-code
// detection and a saturating count of delivered error entries.
module onehot_codec #(
    parameter int BIN_W     = 4,
    parameter int ONE_HOT_W = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 mode_i,
    input  logic [ONE_HOT_W-1:0] data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ONE_HOT_W-1:0] one_hot_o,
    output logic [BIN_W-1:0]     bin_o,
    output logic                 mode_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     err_cnt_o,
    input  logic                 clr_cnt_i
);

    typedef struct packed {
        logic                 mode;
        logic                 err;
        logic [BIN_W-1:0]     bin;
        logic [ONE_HOT_W-1:0] one_hot;
    } entry_t;

    entry_t      res;
    entry_t      head;
    entry_t      tail;
    logic [1:0]  count;
    logic [CNT_W-1:0] err_cnt;
    logic        push;
    logic        pop;
    logic        seen;
    logic        multi;

    always_comb begin
        res      = '0;
        res.mode = mode_i;
        seen     = 1'b0;
        multi    = 1'b0;
        if (!mode_i) begin
            if (int'(data_i[BIN_W-1:0]) < ONE_HOT_W)
                res.one_hot = ONE_HOT_W'(1) << data_i[BIN_W-1:0];
            else
                res.err = 1'b1;
        end else begin
            // Ascending scan: the first set bit found is the reported (lowest) index.
            for (int unsigned i = 0; i < ONE_HOT_W; i++) begin
                if (data_i[i]) begin
                    if (!seen)
                        res.bin = BIN_W'(i);
                    else
                        multi = 1'b1;
                    seen = 1'b1;
                end
            end
            res.err = !seen || multi;
        end
    end

    assign in_ready_o  = (count != 2'd2);
    assign out_valid_o = (count != 2'd0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // Head register drives the outputs directly; tail only holds the second entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            head    <= '0;
            tail    <= '0;
            err_cnt <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) head <= res;
                end
                2'd1: begin
                    if (push && pop) head <= res;
                    else if (push)   tail <= res;
                end
                default: begin
                    if (pop) head <= tail;
                end
            endcase

            if (push && !pop)
                count <= count + 2'd1;
            else if (pop && !push)
                count <= count - 2'd1;

            if (clr_cnt_i)
                err_cnt <= '0;
            else if (pop && head.err && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end
    end

    assign one_hot_o = head.one_hot;
    assign bin_o     = head.bin;
    assign mode_o    = head.mode;
    assign err_o     = head.err;
    assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_onehot_codec.sv
// Directed bench for onehot_codec: vector tables for both widths plus hand-written
// backpressure, saturation and mid-stream reset sequences.
module tb_onehot_codec;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        in_valid, mode, out_ready, clr;
    logic [15:0] data;
    logic        in_ready, out_valid, out_mode, err;
    logic [15:0] one_hot;
    logic [3:0]  bin;
    logic [7:0]  err_cnt;

    logic        v_valid, v_mode, v_oready, v_clr;
    logic [9:0]  v_data;
    logic        v_ready, v_ovalid, v_omode, v_err;
    logic [9:0]  v_oh;
    logic [3:0]  v_bin;
    logic [7:0]  v_cnt;

    onehot_codec #(.BIN_W(4), .ONE_HOT_W(16), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .mode_i(mode), .data_i(data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .one_hot_o(one_hot), .bin_o(bin), .mode_o(out_mode), .err_o(err),
        .err_cnt_o(err_cnt), .clr_cnt_i(clr)
    );

    onehot_codec #(.BIN_W(4), .ONE_HOT_W(10), .CNT_W(8)) dut10 (
        .clk(clk), .reset_n(reset_n), .in_valid_i(v_valid), .in_ready_o(v_ready),
        .mode_i(v_mode), .data_i(v_data), .out_valid_o(v_ovalid), .out_ready_i(v_oready),
        .one_hot_o(v_oh), .bin_o(v_bin), .mode_o(v_omode), .err_o(v_err),
        .err_cnt_o(v_cnt), .clr_cnt_i(v_clr)
    );

    typedef struct {
        logic        mode;
        logic [15:0] data;
        logic [15:0] exp_oh;
        logic [3:0]  exp_bin;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    vec_t vecs10[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int acc;
        logic [3:0] dv [4];

        reset_n = 1'b0; in_valid = 1'b0; mode = 1'b0; data = '0; out_ready = 1'b1; clr = 1'b0;
        v_valid = 1'b0; v_mode = 1'b0; v_data = '0; v_oready = 1'b1; v_clr = 1'b0;

        for (int i = 0; i < 16; i++)
            vecs.push_back('{1'b0, 16'(i), 16'h0001 << i, 4'd0, 1'b0});
        vecs.push_back('{1'b1, 16'h0400, 16'h0000, 4'd10, 1'b0});
        vecs.push_back('{1'b1, 16'h0000, 16'h0000, 4'd0,  1'b1});
        vecs.push_back('{1'b1, 16'h0120, 16'h0000, 4'd5,  1'b1});
        vecs.push_back('{1'b1, 16'h8000, 16'h0000, 4'd15, 1'b0});
        vecs.push_back('{1'b1, 16'hFFFF, 16'h0000, 4'd0,  1'b1});
        vecs.push_back('{1'b0, 16'hABC3, 16'h0008, 4'd0,  1'b0});

        vecs10.push_back('{1'b0, 16'd12,   16'h0000, 4'd0, 1'b1});
        vecs10.push_back('{1'b0, 16'd9,    16'h0200, 4'd0, 1'b0});
        vecs10.push_back('{1'b0, 16'd15,   16'h0000, 4'd0, 1'b1});
        vecs10.push_back('{1'b0, 16'd0,    16'h0001, 4'd0, 1'b0});
        vecs10.push_back('{1'b1, 16'h0200, 16'h0000, 4'd9, 1'b0});
        vecs10.push_back('{1'b1, 16'h0300, 16'h0000, 4'd8, 1'b1});

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_one_hot",   32'(one_hot),   32'd0);
        check("rst_err_cnt",   32'(err_cnt),   32'd0);
        reset_n = 1'b1;

        // Streaming table, 16-wide instance: result visible one edge after accept.
        foreach (vecs[i]) begin
            in_valid = 1'b1; mode = vecs[i].mode; data = vecs[i].data;
            @(posedge clk); #1;
            check($sformatf("v%0d_valid", i),   32'(out_valid), 32'd1);
            check($sformatf("v%0d_one_hot", i), 32'(one_hot),   32'(vecs[i].exp_oh));
            check($sformatf("v%0d_bin", i),     32'(bin),       32'(vecs[i].exp_bin));
            check($sformatf("v%0d_err", i),     32'(err),       32'(vecs[i].exp_err));
            check($sformatf("v%0d_mode", i),    32'(out_mode),  32'(vecs[i].mode));
            check($sformatf("v%0d_ready", i),   32'(in_ready),  32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain_valid",   32'(out_valid), 32'd0);
        check("drain_err_cnt", 32'(err_cnt),   32'd3);

        // Streaming table, 10-wide instance.
        foreach (vecs10[i]) begin
            v_valid = 1'b1; v_mode = vecs10[i].mode; v_data = vecs10[i].data[9:0];
            @(posedge clk); #1;
            check($sformatf("w%0d_valid", i),   32'(v_ovalid), 32'd1);
            check($sformatf("w%0d_one_hot", i), 32'(v_oh),     32'(vecs10[i].exp_oh));
            check($sformatf("w%0d_bin", i),     32'(v_bin),    32'(vecs10[i].exp_bin));
            check($sformatf("w%0d_err", i),     32'(v_err),    32'(vecs10[i].exp_err));
        end
        v_valid = 1'b0;
        @(posedge clk); #1;
        check("w_drain_valid", 32'(v_ovalid), 32'd0);
        check("w_err_cnt",     32'(v_cnt),    32'd3);

        // Backpressure: four offered, two accepted, head held stable.
        dv[0] = 4'd3; dv[1] = 4'd5; dv[2] = 4'd7; dv[3] = 4'd9;
        acc = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; mode = 1'b0; data = 16'(dv[k]);
            if (in_ready) acc++;
            @(posedge clk); #1;
            check($sformatf("bp%0d_hold_oh", k), 32'(one_hot), 32'h0008);
        end
        check("bp_accepts",   32'(acc),       32'd2);
        check("bp_in_ready",  32'(in_ready),  32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        data = 16'd11;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_pop1_oh",    32'(one_hot),  32'h0020);
        check("bp_pop1_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("bp_third_oh",   32'(one_hot),  32'h0800);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_empty", 32'(out_valid), 32'd0);

        // Saturation: 300 more illegal encodes on top of the 3 already counted.
        for (int k = 0; k < 300; k++) begin
            in_valid = 1'b1; mode = 1'b1; data = 16'h0000;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("sat_err_cnt", 32'(err_cnt), 32'd255);

        // Clear coinciding with an error pop.
        in_valid = 1'b1; mode = 1'b1; data = 16'h0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("clr_pre_err", 32'(err), 32'd1);
        check("clr_pre_cnt", 32'(err_cnt), 32'd255);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_cnt", 32'(err_cnt), 32'd0);

        // Mid-stream reset with the buffer full.
        in_valid = 1'b1; mode = 1'b1; data = 16'h0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_cnt", 32'(err_cnt), 32'd1);
        out_ready = 1'b0;
        in_valid = 1'b1; mode = 1'b1; data = 16'h0003;
        @(posedge clk); #1;
        mode = 1'b0; data = 16'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head_err", 32'(err),      32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_fields",    {15'd0, one_hot, bin, out_mode, err}, 32'd0);
        check("arst_err_cnt",   32'(err_cnt),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; mode = 1'b0; data = 16'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_oh",    32'(one_hot),   32'h0040);
        @(posedge clk); #1;
        check("post_rst_empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_codec.md
# onehot_codec

Parametrised, registered binary/one-hot converter with a selectable per-transaction mode (decode binary to one-hot, or encode one-hot to binary), detection of illegal codes, and a valid/ready handshake on both sides. It succeeds the combinational binary-to-one-hot decoder. It adds a 2-entry output buffer so it can sit between pipelined stages without combinational ready paths. A saturating error counter gives software-visible statistics.

## Interface

Parameters:
- BIN_W, 4, binary code width.
- ONE_HOT_W, 16, one-hot width; legal range 2 .. 2**BIN_W.
- CNT_W, 8, error counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid_i  input  1  input transaction present.
- in_ready_o  output  1  block can accept; registered, 1 when buffer not full.
- mode_i  input  1  0 = decode (binary to one-hot), 1 = encode (one-hot to binary); sampled with the transaction.
- data_i  input  ONE_HOT_W  encode uses all bits; decode uses data_i[BIN_W-1:0] and ignores the rest.
- out_valid_o  output  1  head result present.
- out_ready_i  input  1  downstream accepts head result.
- one_hot_o  output  ONE_HOT_W  decode result; 0 for encode-mode entries.
- bin_o  output  BIN_W  encode result; 0 for decode-mode entries.
- mode_o  output  1  mode of head entry.
- err_o  output  1  head entry was an illegal code.
- err_cnt_o  output  CNT_W  saturating count of delivered error entries.
- clr_cnt_i  input  1  synchronous clear of err_cnt_o.

## Operation

- The input is accepted on a rising edge with in_valid_i && in_ready_o. The result is computed combinationally from data_i/mode_i and written into the 2-entry FIFO.
- Decode: if bin < ONE_HOT_W, one_hot_o = 1 << bin and err = 0. Otherwise one_hot_o = 0 and err = 1.
- Encode with exactly one bit set: bin_o = index of that bit, err = 0.
- Encode with zero bits set: bin_o = 0, err = 1.
- Encode with two or more bits set: bin_o = lowest set index, err = 1.
- FIFO: 2 entries, strict order, count 0..2.
  - in_ready_o = (count != 2), driven from a registered count.
  - Push and pop in the same cycle leave count unchanged. When count = 0, a push and pop cannot coincide because out_valid_o = 0.
- The output always presents the head entry. out_valid_o = (count != 0).
- While out_valid_o = 1 and out_ready_i = 0, all output fields hold stable.
- Error counter:
  - On a pop (out_valid_o && out_ready_i) with head err = 1, it increments by 1, saturating at 2**CNT_W-1.
  - clr_cnt_i has priority over increment: the counter goes to 0 even if an error pops in the same cycle.
- Reset asserted, at any time:
  - count = 0, out_valid_o = 0, in_ready_o = 1.
  - one_hot_o = 0, bin_o = 0, mode_o = 0, err_o = 0, err_cnt_o = 0.
  - In-flight entries are discarded.

## Timing

- Latency is 1 cycle. Accepted at edge N means out_valid_o = 1 after edge N with the result.
- Throughput is 1 transaction/cycle while out_ready_i = 1.
- No combinational path from out_ready_i to in_ready_o, nor from in_valid_i to out_valid_o.
- With out_ready_i = 0, two transactions are accepted. in_ready_o falls after the second accept edge.
- After one pop, in_ready_o rises after that pop edge. The earliest next accept is the following edge.
- err_cnt_o updates on the pop edge; visible the cycle after the pop.

## Test plan

- Reset, then decode bin = 0..15 back-to-back with out_ready_i = 1. Expect one_hot_o = 16'h0001..16'h8000, each 1 cycle after accept, err_o = 0, err_cnt_o = 0.
- Encode data_i = 16'h0400 -> bin_o = 10, err_o = 0. Encode 16'h0000 -> bin_o = 0, err_o = 1. Encode 16'h0120 -> bin_o = 5, err_o = 1. Expect err_cnt_o = 2 after both pops.
- Use ONE_HOT_W = 10, BIN_W = 4 and decode bin = 12 -> one_hot_o = 0, err_o = 1. Decode bin = 9 -> 10'h200.
- Hold out_ready_i = 0 and drive in_valid_i for 4 cycles. Expect exactly 2 accepts, in_ready_o = 0, and outputs stable. Release out_ready_i: results emerge in order and a third accept occurs one edge after the first pop.
- Feed 300 illegal encodes (CNT_W = 8): err_cnt_o saturates at 255. Assert clr_cnt_i in a cycle that also pops an error: err_cnt_o = 0.
- With 2 entries buffered, assert reset_n = 0 mid-stream. Outputs are 0 immediately (asynchronous) and in_ready_o = 1. After release, the first accept produces its result 1 cycle later with no stale entries.
